fetch_unit_nw: RTL and testbench

//  Parametrised N-wide instruction fetch unit for the superscalar MIPS core. Owns the PC,

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 106 ++++++++++
 rtl/fetch_unit_nw.sv | 114 +++++++++++
 tb/tb_fetch_unit_nw.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg : constants, helpers and entry type shared by the fetch unit
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

   // Width needed to express a lane count of 0..nlane inclusive.
   function automatic int lane_cnt_w(input int nlane);
      return $clog2(nlane + 1);
   endfunction

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue : NLANE-in / NLANE-out circular buffer of {pc, instr} entries
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
   import fetch_pkg::*;
#(
   parameter int NLANE  = 3,
   parameter int XLEN   = fetch_pkg::XLEN,
   parameter int QDEPTH = 8,
   localparam int PTR_W = $clog2(QDEPTH),
   localparam int CNT_W = $clog2(QDEPTH) + 1,
   localparam int DEQ_W = lane_cnt_w(NLANE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [NLANE*XLEN-1:0]  wr_pc,
   input  logic [NLANE*XLEN-1:0]  wr_instr,
   input  logic [DEQ_W-1:0]       deq_cnt,
   output logic [NLANE-1:0]       rd_valid,
   output logic [NLANE*XLEN-1:0]  rd_pc,
   output logic [NLANE*XLEN-1:0]  rd_instr,
   output logic [CNT_W-1:0]       count
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   entry_t           mem_q [QDEPTH];
   entry_t           mem_d [QDEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] deq_eff;

   always_comb begin
      // An over-large dequeue is clamped so the pointers can never cross.
      deq_eff = (CNT_W'(deq_cnt) > count_q) ? count_q : CNT_W'(deq_cnt);
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
               mem_d[tail_q + PTR_W'(i)].pc    = wr_pc[i*XLEN +: XLEN];
               mem_d[tail_q + PTR_W'(i)].instr = wr_instr[i*XLEN +: XLEN];
            end
            tail_d = tail_q + PTR_W'(NLANE);
         end
         head_d  = head_q + PTR_W'(deq_eff);
         count_d = count_q + (wr_en ? CNT_W'(NLANE) : '0) - deq_eff;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      rd_valid = '0;
      rd_pc    = '0;
      rd_instr = '0;
      for (int i = 0; i < NLANE; i++) begin
         rd_valid[i] = (count_q > CNT_W'(i));
         // Invalid lanes present zero rather than stale storage contents.
         rd_pc[i*XLEN +: XLEN]    = rd_valid[i] ? mem_q[head_q + PTR_W'(i)].pc : '0;
         rd_instr[i*XLEN +: XLEN] = rd_valid[i] ? mem_q[head_q + PTR_W'(i)].instr
                                                : XLEN'(INSTR_NOP);
      end
   end

   assign count = count_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && !flush && (CNT_W'(deq_cnt) > count_q))
         $error("fetch_queue: deq_cnt %0d exceeds occupancy %0d", deq_cnt, count_q);
   end
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_unit_nw.sv
// ----------------------------------------------------------------------------
// fetch_unit_nw : N-wide instruction fetch (PC, fire/redirect control, queue)
//                 Optional FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
// Revision      : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit_nw
   import fetch_pkg::*;
#(
   parameter int              NLANE    = 3,
   parameter int              XLEN     = fetch_pkg::XLEN,
   parameter int              QDEPTH   = 8,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   localparam int             DEQ_W    = lane_cnt_w(NLANE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fetch_en,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic [NLANE*XLEN-1:0]  imem_addr,
   input  logic [NLANE*XLEN-1:0]  imem_rdata,
   output logic [NLANE-1:0]       out_valid,
   output logic [NLANE*XLEN-1:0]  out_instr,
   output logic [NLANE*XLEN-1:0]  out_pc,
   input  logic [DEQ_W-1:0]       deq_cnt
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_stall_cyc,
   output logic [31:0]            perf_redirects
`endif
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] q_count;
   logic             room;
   logic             fire;

   generate
      for (genvar i = 0; i < NLANE; i++) begin : g_lane_addr
         assign imem_addr[i*XLEN +: XLEN] = pc_q + XLEN'(4*i);
      end
   endgenerate

   // Space is judged on occupancy before this cycle's dequeue.
   assign room = (CNT_W'(QDEPTH) - q_count) >= CNT_W'(NLANE);
   assign fire = fetch_en && !redirect_valid && room;

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid)
         pc_d = redirect_pc;
      else if (fire)
         pc_d = pc_q + XLEN'(4*NLANE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   fetch_queue #(
      .NLANE  (NLANE),
      .XLEN   (XLEN),
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .wr_en    (fire),
      .wr_pc    (imem_addr),
      .wr_instr (imem_rdata),
      .deq_cnt  (deq_cnt),
      .rd_valid (out_valid),
      .rd_pc    (out_pc),
      .rd_instr (out_instr),
      .count    (q_count)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] redir_q, redir_d;

   always_comb begin
      stall_d = stall_q;
      redir_d = redir_q;
      if (fetch_en && !redirect_valid && !room && (stall_q != '1))
         stall_d = stall_q + 32'd1;
      if (redirect_valid && (redir_q != '1))
         redir_d = redir_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         redir_q <= '0;
      end else begin
         stall_q <= stall_d;
         redir_q <= redir_d;
      end
   end

   assign perf_stall_cyc = stall_q;
   assign perf_redirects = redir_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit_nw.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit_nw : directed bench for fetch_unit_nw (NLANE=3, QDEPTH=8)
// Revision         : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit_nw;

   localparam int NL = 3;
   localparam int QD = 8;

   logic        clk            = 1'b0;
   logic        rst_n          = 1'b0;
   logic        fetch_en       = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic [1:0]  deq_cnt        = 2'd0;
   logic [95:0] imem_addr;
   logic [95:0] imem_rdata;
   logic [2:0]  out_valid;
   logic [95:0] out_instr;
   logic [95:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cyc;
   logic [31:0] perf_redirects;
`endif

   int          checks = 0;
   int          errors = 0;
   int          exp_count;
   logic [31:0] exp_pc;
   int          exp_stall;
   int          exp_redir;

   always #5 clk = ~clk;

   fetch_unit_nw #(
      .NLANE    (NL),
      .XLEN     (32),
      .QDEPTH   (QD),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .deq_cnt        (deq_cnt)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_redirects (perf_redirects)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   always_comb begin
      imem_rdata = '0;
      for (int i = 0; i < NL; i++)
         imem_rdata[i*32 +: 32] = mem_word(imem_addr[i*32 +: 32]);
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue always holds consecutive PCs ending just below the fetch PC.
   task automatic check_model(input string tag);
      logic [95:0] e_addr, e_pc, e_ins;
      logic [2:0]  e_v;
      logic [31:0] hp, p;
      e_addr = '0; e_pc = '0; e_ins = '0; e_v = '0;
      hp = exp_pc - 32'(4*exp_count);
      for (int i = 0; i < NL; i++) begin
         e_addr[i*32 +: 32] = exp_pc + 32'(4*i);
         if (i < exp_count) begin
            p = hp + 32'(4*i);
            e_v[i] = 1'b1;
            e_pc[i*32 +: 32]  = p;
            e_ins[i*32 +: 32] = mem_word(p);
         end
      end
      chk({tag, "_addr"},  imem_addr, e_addr);
      chk({tag, "_valid"}, 96'(out_valid), 96'(e_v));
      chk({tag, "_pc"},    out_pc, e_pc);
      chk({tag, "_instr"}, out_instr, e_ins);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, "_stall"}, 96'(perf_stall_cyc), 96'(exp_stall));
      chk({tag, "_redir"}, 96'(perf_redirects), 96'(exp_redir));
`endif
   endtask

   task automatic cyc(input logic en, input logic rv, input logic [31:0] rpc,
                      input int dq, input string tag);
      int   d;
      logic f;
      fetch_en       = en;
      redirect_valid = rv;
      redirect_pc    = rpc;
      deq_cnt        = 2'(dq);
      @(negedge clk);
      check_model(tag);
      f = en && !rv && ((QD - exp_count) >= NL);
      if (en && !rv && !f) exp_stall++;
      if (rv) begin
         exp_count = 0;
         exp_pc    = rpc;
         exp_redir++;
      end else begin
         d = (dq > exp_count) ? exp_count : dq;
         exp_count = exp_count + (f ? NL : 0) - d;
         if (f) exp_pc = exp_pc + 32'(4*NL);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic en;
      int   dq;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 96'(out_valid), 96'h0);
      chk("rst_pc",    out_pc,    96'h0);
      chk("rst_instr", out_instr, 96'h0);
      chk("rst_addr",  imem_addr, {32'd8, 32'd4, 32'd0});
      exp_pc = 32'h0; exp_count = 0; exp_stall = 0; exp_redir = 0;
      rst_n = 1'b1;

      // Fill: two fires, third blocked with PC holding at 24.
      cyc(1'b1, 1'b0, 32'h0, 0, "t1a");
      chk("t1_valid", 96'(out_valid), 96'h7);
      chk("t1_pc",    out_pc, {32'd8, 32'd4, 32'd0});
      cyc(1'b1, 1'b0, 32'h0, 0, "t1b");
      chk("t1_addr24", imem_addr, {32'd32, 32'd28, 32'd24});
      cyc(1'b1, 1'b0, 32'h0, 0, "t1c");
      chk("t1_hold",   imem_addr, {32'd32, 32'd28, 32'd24});

      // Steady full-width drain.
      repeat (6) cyc(1'b1, 1'b0, 32'h0, 3, "t2");
      chk("t2_pc",    out_pc, {32'd80, 32'd76, 32'd72});
      chk("t2_valid", 96'(out_valid), 96'h7);

      // Partial drain with concurrent fire.
      cyc(1'b1, 1'b0, 32'h0, 1, "t3");
      chk("t3_pc",   out_pc, {32'd84, 32'd80, 32'd76});
      chk("t3_addr", imem_addr, {32'd104, 32'd100, 32'd96});

      // Redirect overrides dequeue and fetch.
      cyc(1'b1, 1'b1, 32'h100, 2, "t4a");
      chk("t4_valid0", 96'(out_valid), 96'h0);
      chk("t4_addr",   imem_addr, {32'h108, 32'h104, 32'h100});
      cyc(1'b1, 1'b0, 32'h0, 0, "t4b");
      chk("t4_pc",     out_pc, {32'h108, 32'h104, 32'h100});
      chk("t4_valid",  96'(out_valid), 96'h7);

      // PC wrap at the top of the address space, then pointer wrap.
      cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 0, "t5a");
      chk("t5_addr", imem_addr, {32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
      cyc(1'b1, 1'b0, 32'h0, 0, "t5b");
      chk("t5_next", imem_addr, {32'h0000_000C, 32'h0000_0008, 32'h0000_0004});
      chk("t5_pc",   out_pc, {32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
      for (int k = 0; k < 20; k++) begin
         en = ($urandom_range(0, 3) != 0);
         dq = $urandom_range(0, (exp_count < NL) ? exp_count : NL);
         cyc(en, 1'b0, 32'h0, dq, "t5w");
      end

      // Reset in the middle of traffic with five entries queued.
      cyc(1'b1, 1'b1, 32'h0, 0, "t6a");
      cyc(1'b1, 1'b0, 32'h0, 0, "t6b");
      cyc(1'b1, 1'b0, 32'h0, 1, "t6c");
      chk("t6_pre", out_pc, {32'd12, 32'd8, 32'd4});
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 96'(out_valid), 96'h0);
      chk("t6_addr",  imem_addr, {32'd8, 32'd4, 32'd0});
      chk("t6_pc",    out_pc, 96'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("t6_stall0", 96'(perf_stall_cyc), 96'h0);
      chk("t6_redir0", 96'(perf_redirects), 96'h0);
`endif
      exp_pc = 32'h0; exp_count = 0; exp_stall = 0; exp_redir = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Stall counting only on blocked enabled cycles.
      cyc(1'b1, 1'b0, 32'h0, 0, "t7a");
      cyc(1'b1, 1'b0, 32'h0, 0, "t7b");
      cyc(1'b1, 1'b0, 32'h0, 0, "t7c");
      cyc(1'b1, 1'b0, 32'h0, 0, "t7d");
      cyc(1'b0, 1'b0, 32'h0, 0, "t7e");
      cyc(1'b1, 1'b1, 32'h40, 0, "t7f");
      cyc(1'b0, 1'b0, 32'h0, 0, "t7g");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
